// File: rtl/tt6581_pdm_pkg.sv
// rtl/tt6581_pdm_pkg.sv - shared constants and helpers for the PDM CIC decimator
package tt6581_pdm_pkg;

    localparam int NUM_CH_MAX = 8;
    localparam int ORDER_MIN  = 1;
    localparam int ORDER_MAX  = 4;
    localparam int DECIM_MIN  = 4;
    localparam int DECIM_MAX  = 1024;
    localparam int OUT_W_MIN  = 8;
    localparam int OUT_W_MAX  = 32;

    localparam logic signed [1:0] PDM_POS = 2'sb01;
    localparam logic signed [1:0] PDM_NEG = 2'sb11;

    // Bit growth of an ORDER-stage CIC at ratio DECIM, plus the 2-bit input.
    function automatic int cic_acc_w(input int order, input int decim);
        return order * $clog2(decim) + 2;
    endfunction

endpackage

// File: rtl/tt6581_cic_ch.sv
// rtl/tt6581_cic_ch.sv - one CIC decimator channel: integrators, combs, output scaling
module tt6581_cic_ch
    import tt6581_pdm_pkg::*;
#(
    parameter int ORDER = 3,
    parameter int DECIM = 64,
    parameter int OUT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr,
    input  logic             dec_stb,
    input  logic             pdm_i,
    output logic [OUT_W-1:0] sample_o
);

    localparam int ACC_W = cic_acc_w(ORDER, DECIM);

    logic signed [ACC_W-1:0] integ_q [ORDER];
    logic signed [ACC_W-1:0] integ_d [ORDER];
    logic signed [ACC_W-1:0] dly_q   [ORDER];
    logic signed [ACC_W-1:0] dly_d   [ORDER];
    logic signed [ACC_W-1:0] comb_v  [ORDER];
    logic signed [1:0]       in_val;
    logic signed [ACC_W-1:0] comb_out;

    // The comb chain reads the integrator's next value so the result includes
    // the input bit of the strobe cycle itself.
    always_comb begin
        in_val     = pdm_i ? PDM_POS : PDM_NEG;
        integ_d[0] = integ_q[0] + ACC_W'(in_val);
        for (int i = 1; i < ORDER; i++) begin
            integ_d[i] = integ_q[i] + integ_d[i-1];
        end
        comb_v[0] = integ_d[ORDER-1] - dly_q[0];
        dly_d[0]  = dec_stb ? integ_d[ORDER-1] : dly_q[0];
        for (int j = 1; j < ORDER; j++) begin
            comb_v[j] = comb_v[j-1] - dly_q[j];
            dly_d[j]  = dec_stb ? comb_v[j-1] : dly_q[j];
        end
        if (clr) begin
            for (int i = 0; i < ORDER; i++) begin
                integ_d[i] = '0;
                dly_d[i]   = '0;
            end
        end
        comb_out = comb_v[ORDER-1];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < ORDER; i++) begin
                integ_q[i] <= '0;
                dly_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < ORDER; i++) begin
                integ_q[i] <= integ_d[i];
                dly_q[i]   <= dly_d[i];
            end
        end
    end

    if (ACC_W > OUT_W) begin : g_trunc
        logic unused_lsb;
        assign sample_o   = comb_out[ACC_W-1 -: OUT_W];
        assign unused_lsb = ^comb_out[ACC_W-OUT_W-1:0];
    end else begin : g_ext
        assign sample_o = OUT_W'(comb_out);
    end

endmodule

// File: rtl/tt6581_pdm_decim.sv
// rtl/tt6581_pdm_decim.sv - multi-channel PDM to PCM CIC decimator with valid/ready output
module tt6581_pdm_decim
    import tt6581_pdm_pkg::*;
#(
    parameter int NUM_CH = 1,
    parameter int ORDER  = 3,
    parameter int DECIM  = 64,
    parameter int OUT_W  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    en_i,
    input  logic [NUM_CH-1:0]       pdm_i,
    output logic [NUM_CH*OUT_W-1:0] sample_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic                    overrun_o,
    input  logic                    clr_ovr_i
);

    localparam int CNT_W  = $clog2(DECIM);
    localparam int WARM_W = $clog2(ORDER + 1);

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [WARM_W-1:0]       warm_q, warm_d;
    logic [NUM_CH*OUT_W-1:0] sample_q, sample_d;
    logic                    valid_q, valid_d;
    logic                    overrun_q, overrun_d;
    logic [NUM_CH*OUT_W-1:0] ch_sample;
    logic                    dec_stb;
    logic                    clr;
    logic                    new_res;
    logic                    drop;

    assign clr     = ~en_i;
    assign dec_stb = en_i && (cnt_q == CNT_W'(DECIM - 1));

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        tt6581_cic_ch #(
            .ORDER (ORDER),
            .DECIM (DECIM),
            .OUT_W (OUT_W)
        ) u_ch (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .clr      (clr),
            .dec_stb  (dec_stb),
            .pdm_i    (pdm_i[k]),
            .sample_o (ch_sample[k*OUT_W +: OUT_W])
        );
    end

    always_comb begin
        cnt_d     = cnt_q + CNT_W'(1);
        warm_d    = warm_q;
        sample_d  = sample_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        new_res   = 1'b0;
        drop      = 1'b0;

        // The first ORDER results still carry start-up transient; swallow them.
        if (dec_stb) begin
            if (warm_q != WARM_W'(ORDER)) begin
                warm_d = warm_q + WARM_W'(1);
            end else begin
                new_res = 1'b1;
            end
        end

        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
        if (new_res) begin
            if (valid_q && !ready_i) begin
                drop = 1'b1;
            end else begin
                sample_d = ch_sample;
                valid_d  = 1'b1;
            end
        end

        if (clr_ovr_i) begin
            overrun_d = 1'b0;
        end
        if (drop) begin
            overrun_d = 1'b1;
        end

        if (!en_i) begin
            cnt_d    = '0;
            warm_d   = '0;
            sample_d = '0;
            valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            warm_q    <= '0;
            sample_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            warm_q    <= warm_d;
            sample_q  <= sample_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign sample_o  = sample_q;
    assign valid_o   = valid_q;
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_tt6581_pdm_decim.sv
// tb/tb_tt6581_pdm_decim.sv - directed self-checking bench for tt6581_pdm_decim
module tb_tt6581_pdm_decim;

    logic        clk;
    logic        rst_n;
    logic        en_a, ready_a, clr_a;
    logic [1:0]  pdm_a;
    logic [31:0] sample_a;
    logic        valid_a, ovr_a;
    logic        en_b, ready_b, clr_b;
    logic [0:0]  pdm_b;
    logic [15:0] sample_b;
    logic        valid_b, ovr_b;

    int   checks = 0;
    int   errors = 0;
    logic seen_a, seen_b;

    tt6581_pdm_decim #(.NUM_CH(2), .ORDER(3), .DECIM(16), .OUT_W(16)) u_a (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .en_i      (en_a),
        .pdm_i     (pdm_a),
        .sample_o  (sample_a),
        .valid_o   (valid_a),
        .ready_i   (ready_a),
        .overrun_o (ovr_a),
        .clr_ovr_i (clr_a)
    );

    tt6581_pdm_decim #(.NUM_CH(1), .ORDER(4), .DECIM(1024), .OUT_W(16)) u_b (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .en_i      (en_b),
        .pdm_i     (pdm_b),
        .sample_o  (sample_b),
        .valid_o   (valid_b),
        .ready_i   (ready_b),
        .overrun_o (ovr_b),
        .clr_ovr_i (clr_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            seen_a = seen_a | valid_a;
            seen_b = seen_b | valid_b;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en_a = 1'b0; ready_a = 1'b1; clr_a = 1'b0; pdm_a = 2'b01;
        en_b = 1'b0; ready_b = 1'b1; clr_b = 1'b0; pdm_b = 1'b1;
        seen_a = 1'b0; seen_b = 1'b0;
        #20;
        chk("rst_sample", sample_a, 0);
        chk("rst_valid", valid_a, 0);
        chk("rst_ovr", ovr_a, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(2);

        // ch0 constant 1, ch1 constant 0, consumer always ready
        en_a = 1'b1;
        seen_a = 1'b0;
        step(63);
        chk("warmup_quiet", seen_a, 0);
        step(1);
        chk("first_valid_64", valid_a, 1);
        chk("const1_lane0", $signed(sample_a[15:0]), 4096);
        chk("const0_lane1", $signed(sample_a[31:16]), -4096);
        for (int p = 0; p < 3; p++) begin
            step(16);
            chk("period_valid", valid_a, 1);
            chk("period_lane0", $signed(sample_a[15:0]), 4096);
            chk("period_lane1", $signed(sample_a[31:16]), -4096);
        end

        // en_i dropped while a sample is held
        ready_a = 1'b0;
        en_a = 1'b0;
        step(1);
        chk("en_drop_valid", valid_a, 0);
        chk("en_drop_sample", sample_a, 0);
        ready_a = 1'b1;

        // alternating streams on both lanes
        en_a = 1'b1;
        for (int i = 0; i < 64; i++) begin
            pdm_a = i[0] ? 2'b10 : 2'b01;
            step(1);
        end
        chk("alt_valid", valid_a, 1);
        chk("alt_lane0", $signed(sample_a[15:0]), 0);
        chk("alt_lane1", $signed(sample_a[31:16]), 0);

        // stalled consumer: hold, drop, sticky overrun
        en_a = 1'b0;
        step(1);
        pdm_a = 2'b01;
        ready_a = 1'b0;
        en_a = 1'b1;
        step(64);
        chk("stall_valid", valid_a, 1);
        chk("stall_lane0", $signed(sample_a[15:0]), 4096);
        chk("stall_ovr0", ovr_a, 0);
        pdm_a = 2'b10;
        step(48);
        chk("frozen_valid", valid_a, 1);
        chk("frozen_lane0", $signed(sample_a[15:0]), 4096);
        chk("frozen_lane1", $signed(sample_a[31:16]), -4096);
        chk("overrun_set", ovr_a, 1);
        ready_a = 1'b1;
        step(1);
        chk("xfer_valid", valid_a, 0);
        chk("ovr_sticky", ovr_a, 1);
        clr_a = 1'b1;
        step(1);
        chk("ovr_cleared", ovr_a, 0);
        clr_a = 1'b0;
        ready_a = 1'b0;
        step(14);
        chk("swap_valid", valid_a, 1);
        chk("swap_lane0", $signed(sample_a[15:0]), -4096);
        chk("swap_lane1", $signed(sample_a[31:16]), 4096);
        step(15);
        clr_a = 1'b1;
        step(1);
        chk("set_wins_clr", ovr_a, 1);
        chk("set_wins_lane0", $signed(sample_a[15:0]), -4096);
        clr_a = 1'b0;

        // asynchronous reset mid-cycle
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", valid_a, 0);
        chk("async_sample", sample_a, 0);
        chk("async_ovr", ovr_a, 0);
        #2;
        rst_n = 1'b1;
        en_a = 1'b0;
        ready_a = 1'b1;
        @(posedge clk);
        #1;
        en_a = 1'b1;
        pdm_a = 2'b01;
        seen_a = 1'b0;
        step(63);
        chk("rewarm_quiet", seen_a, 0);
        step(1);
        chk("rewarm_valid", valid_a, 1);
        chk("rewarm_lane0", $signed(sample_a[15:0]), 4096);
        chk("rewarm_lane1", $signed(sample_a[31:16]), -4096);

        // order 4, ratio 1024: 42-bit accumulators that wrap
        en_b = 1'b1;
        seen_b = 1'b0;
        step(5119);
        chk("wide_warmup_quiet", seen_b, 0);
        step(1);
        chk("wide_valid", valid_b, 1);
        chk("wide_sample", $signed(sample_b), 16384);
        chk("wide_ovr", ovr_b, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
